// File: rtl/regfile_context_ctrl_pkg.sv
// Shared encodings and constants for the register-file context controller.
package regfile_context_ctrl_pkg;

    localparam int RF_NUM_REGS    = 31;
    localparam int RF_IDX_W       = 5;
    localparam int MAU_ADDR_SHIFT = 2;

    localparam logic [4:0] RF_ZERO_IDX = 5'd31;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'b00,
        CMD_DUMP = 2'b01,
        CMD_RUN  = 2'b10,
        CMD_HALT = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_DUMP_RD  = 3'd2,
        ST_DUMP_CAP = 3'd3,
        ST_DUMP_OUT = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_context_ctrl_if.sv
// Host command, load/dump streams and register-file maintenance port bundle.
interface regfile_context_ctrl_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_error;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        mau_clk_en;
    logic [31:0] mau_address;
    logic [31:0] mau_data_write;
    logic        mau_wren;
    logic [31:0] rf_read_data;
    logic        alive;
    logic        busy;

    modport master (
        output cmd_valid, cmd_op, in_data, in_valid, out_ready, rf_read_data,
        input  cmd_ready, cmd_error, in_ready, out_data, out_valid,
               mau_clk_en, mau_address, mau_data_write, mau_wren, alive, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, in_data, in_valid, out_ready, rf_read_data,
        output cmd_ready, cmd_error, in_ready, out_data, out_valid,
               mau_clk_en, mau_address, mau_data_write, mau_wren, alive, busy
    );

endinterface

// File: rtl/regfile_context_ctrl.sv
// Loads/dumps the full register context over the register file's maintenance
// port and owns the CPU alive flag; maintenance traffic only while not alive.
module regfile_context_ctrl
    import regfile_context_ctrl_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int IDX_W    = RF_IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_context_ctrl_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_e           r_state;
    state_e           w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_alive;
    logic [31:0]      r_out_data;
    logic             r_out_valid;
    logic             r_cmd_error;

    logic w_cmd_fire;
    logic w_in_fire;
    logic w_out_fire;
    logic w_idx_last;
    logic w_xfer_cmd;
    logic w_xfer_start;

    assign w_cmd_fire   = bus.cmd_valid & bus.cmd_ready;
    assign w_in_fire    = bus.in_valid & bus.in_ready;
    assign w_out_fire   = r_out_valid & bus.out_ready & (r_state == ST_DUMP_OUT);
    assign w_idx_last   = (r_idx == LAST_IDX);
    assign w_xfer_cmd   = (bus.cmd_op == CMD_LOAD) | (bus.cmd_op == CMD_DUMP);
    assign w_xfer_start = w_cmd_fire & w_xfer_cmd & ~r_alive;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer_start && (bus.cmd_op == CMD_LOAD)) begin
                    w_next_state = ST_LOAD;
                end else if (w_xfer_start) begin
                    w_next_state = ST_DUMP_RD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_in_fire && w_idx_last) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_DUMP_RD:  w_next_state = ST_DUMP_CAP;
            ST_DUMP_CAP: w_next_state = ST_DUMP_OUT;
            ST_DUMP_OUT: begin
                if (w_out_fire && w_idx_last) begin
                    w_next_state = ST_IDLE;
                end else if (w_out_fire) begin
                    w_next_state = ST_DUMP_RD;
                end else begin
                    w_next_state = ST_DUMP_OUT;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Handshake and maintenance-port drive; the register file samples the
    // read address on the DUMP_RD edge so data is captured one state later.
    always_comb begin
        bus.cmd_ready      = 1'b0;
        bus.in_ready       = 1'b0;
        bus.mau_clk_en     = 1'b0;
        bus.mau_wren       = 1'b0;
        bus.mau_address    = 32'd0;
        bus.mau_data_write = 32'd0;
        bus.busy           = 1'b1;
        case (r_state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            ST_LOAD: begin
                bus.in_ready       = 1'b1;
                bus.mau_clk_en     = bus.in_valid;
                bus.mau_wren       = bus.in_valid;
                bus.mau_address    = 32'(r_idx) << MAU_ADDR_SHIFT;
                bus.mau_data_write = bus.in_data;
            end
            ST_DUMP_RD: begin
                bus.mau_clk_en  = 1'b1;
                bus.mau_address = 32'(r_idx) << MAU_ADDR_SHIFT;
            end
            ST_DUMP_CAP: bus.busy = 1'b1;
            ST_DUMP_OUT: bus.busy = 1'b1;
            default:     bus.busy = 1'b0;
        endcase
    end

    // Index counter, alive flag, dump word register and error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_alive     <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_valid <= 1'b0;
            r_cmd_error <= 1'b0;
        end else begin
            r_cmd_error <= (r_state == ST_IDLE) & w_cmd_fire & w_xfer_cmd & r_alive;

            if ((r_state == ST_IDLE) && w_xfer_start) begin
                r_idx <= '0;
            end else if (((r_state == ST_LOAD) && w_in_fire && !w_idx_last) ||
                         (w_out_fire && !w_idx_last)) begin
                r_idx <= r_idx + IDX_W'(1);
            end else begin
                r_idx <= r_idx;
            end

            if ((r_state == ST_IDLE) && w_cmd_fire && (bus.cmd_op == CMD_RUN)) begin
                r_alive <= 1'b1;
            end else if ((r_state == ST_IDLE) && w_cmd_fire && (bus.cmd_op == CMD_HALT)) begin
                r_alive <= 1'b0;
            end else begin
                r_alive <= r_alive;
            end

            if (r_state == ST_DUMP_CAP) begin
                r_out_data  <= bus.rf_read_data;
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

    assign bus.alive     = r_alive;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.cmd_error = r_cmd_error;

endmodule

// File: tb/tb_regfile_context_ctrl.sv
// Randomized bench: register-file model on the maintenance port, array-based
// reference of register contents, load/dump/backpressure/guard/reset scenarios.
module tb_regfile_context_ctrl;
    import regfile_context_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] ref_regs [RF_NUM_REGS];
    logic [31:0] rf_mem [32];
    logic [4:0]  rf_rd_idx;

    regfile_context_ctrl_if bus ();

    regfile_context_ctrl #(.NUM_REGS(RF_NUM_REGS), .IDX_W(RF_IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file: synchronous write, registered read address, index 31 reads zero.
    always @(posedge clk) begin
        if (bus.mau_clk_en && !bus.alive) begin
            if (bus.mau_wren && (bus.mau_address[6:2] != RF_ZERO_IDX)) begin
                rf_mem[bus.mau_address[6:2]] <= bus.mau_data_write;
            end
            rf_rd_idx <= bus.mau_address[6:2];
        end
    end
    assign bus.rf_read_data = (rf_rd_idx == RF_ZERO_IDX) ? 32'd0 : rf_mem[rf_rd_idx];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic issue_cmd(input logic [1:0] op);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        @(negedge clk);
        check("cmd_ready", bus.cmd_ready, 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // mode 0: 0x1000_0000+i back-to-back, 1: valid pattern 1,0,0,..., 2: random gaps/data
    task automatic do_load(input int n_words, input int mode);
        int i = 0;
        int cyc = 0;
        logic [31:0] d;
        issue_cmd(CMD_LOAD);
        while (i < n_words && cyc < 1000) begin
            d = (mode == 0) ? 32'h1000_0000 + i : $urandom;
            bus.in_data  = d;
            bus.in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            @(negedge clk);
            check("load_in_ready", bus.in_ready, 32'd1);
            check("load_cmd_ready", bus.cmd_ready, 32'd0);
            check("load_wren", bus.mau_wren, bus.in_valid);
            check("load_clk_en", bus.mau_clk_en, bus.in_valid);
            if (bus.in_valid) begin
                check("load_addr", bus.mau_address, i * 4);
                check("load_data", bus.mau_data_write, d);
            end
            @(posedge clk);
            if (bus.in_valid) begin
                ref_regs[i] = d;
                i++;
            end
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (i != n_words) check("load_timeout", i, n_words);
        if (n_words == RF_NUM_REGS) begin
            @(negedge clk);
            check("load_done_busy", bus.busy, 32'd0);
            check("load_done_in_ready", bus.in_ready, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    // mode 0: out_ready always 1, 1: word 7 held off 5 cycles, 2: random backpressure
    task automatic do_dump(input int mode);
        int i = 0;
        int cyc = 0;
        int stall = 0;
        logic hs;
        issue_cmd(CMD_DUMP);
        while (i < RF_NUM_REGS && cyc < 2000) begin
            if (mode == 1)      bus.out_ready = !(i == 7 && bus.out_valid && stall < 5);
            else if (mode == 2) bus.out_ready = ($urandom_range(0, 3) != 0);
            else                bus.out_ready = 1'b1;
            cyc++;
            @(negedge clk);
            check("dump_wren", bus.mau_wren, 32'd0);
            check("dump_in_ready", bus.in_ready, 32'd0);
            if (bus.out_valid) begin
                check("dump_data", bus.out_data, ref_regs[i]);
                if (!bus.out_ready) begin
                    check("dump_stall_clk_en", bus.mau_clk_en, 32'd0);
                    stall++;
                end else if (mode == 0) begin
                    check("dump_rate", cyc, 3 * (i + 1));
                end
            end
            hs = bus.out_valid && bus.out_ready;
            @(posedge clk);
            if (hs) i++;
            #1;
        end
        bus.out_ready = 1'b1;
        if (i != RF_NUM_REGS) check("dump_timeout", i, RF_NUM_REGS);
        if (mode == 1) check("dump_stall_cycles", stall, 5);
        @(negedge clk);
        check("dump_done_busy", bus.busy, 32'd0);
        check("dump_done_valid", bus.out_valid, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic guarded_cmd(input logic [1:0] op);
        issue_cmd(op);
        @(negedge clk);
        check("guard_error", bus.cmd_error, 32'd1);
        check("guard_busy", bus.busy, 32'd0);
        check("guard_clk_en", bus.mau_clk_en, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("guard_error_pulse", bus.cmd_error, 32'd0);
        check("guard_idle", bus.cmd_ready, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 32'd1);
        check("rst_in_ready", bus.in_ready, 32'd0);
        check("rst_busy", bus.busy, 32'd0);
        check("rst_alive", bus.alive, 32'd0);
        check("rst_out_valid", bus.out_valid, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_cmd_error", bus.cmd_error, 32'd0);
        check("rst_clk_en", bus.mau_clk_en, 32'd0);
        check("rst_wren", bus.mau_wren, 32'd0);
        check("rst_addr", bus.mau_address, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        do_load(RF_NUM_REGS, 0);
        do_dump(0);

        issue_cmd(CMD_RUN);
        @(negedge clk);
        check("run_alive", bus.alive, 32'd1);
        @(posedge clk);
        #1;
        guarded_cmd(CMD_LOAD);
        guarded_cmd(CMD_DUMP);
        issue_cmd(CMD_HALT);
        @(negedge clk);
        check("halt_alive", bus.alive, 32'd0);
        @(posedge clk);
        #1;

        do_load(RF_NUM_REGS, 1);
        do_dump(1);
        do_load(RF_NUM_REGS, 2);
        do_dump(2);

        do_load(10, 2);
        reset = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 32'd0);
        check("midrst_alive", bus.alive, 32'd0);
        check("midrst_in_ready", bus.in_ready, 32'd0);
        check("midrst_wren", bus.mau_wren, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_dump(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
